// File: rtl/control_unit_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, ALU/PC selects,
// FSM state encoding and the decoded control bundle.
package control_unit_pkg;

  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_ANDI = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_LBU  = 4'h6;
  localparam logic [3:0] OP_LBS  = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BGT  = 4'h9;
  localparam logic [3:0] OP_BLT  = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_SV   = 4'hF;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_SUB = 2'b10;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JMP  = 2'b10;
  localparam logic [1:0] PC_RET  = 2'b11;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  // Opcode-level controls; strobes here mean "this opcode uses it" and are
  // narrowed to the right stage by the FSM output logic.
  typedef struct packed {
    logic [1:0] pcsrc;
    logic       rb;
    logic       enw1;
    logic       enw2;
    logic       alusrc;
    logic       ext;
    logic       ext_late;  // extender select once the data byte is in flight
    logic [1:0] aluop;
    logic       addaddr;
    logic       adddata;
    logic       memr;
    logic       memw;
    logic       wb;
    logic       mode;
    logic       dst;
    logic       is_br;
  } ctrl_t;

endpackage

// File: rtl/control_unit_decode.sv
// Combinational opcode -> control table. Stage gating lives in control_unit.
module control_unit_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] i_opcode,
  input  logic       i_mode,
  output ctrl_t      o_ctrl
);

  // Opcode table; unlisted fields stay 0
  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OP_AND, OP_ADD, OP_SUB: begin
        o_ctrl.aluop = i_opcode[1:0];
        o_ctrl.dst   = 1'b1;
        o_ctrl.enw1  = 1'b1;
      end
      OP_ANDI: begin
        o_ctrl.alusrc = 1'b1;
        o_ctrl.aluop  = ALU_AND;
        o_ctrl.dst    = 1'b1;
        o_ctrl.enw1   = 1'b1;
      end
      OP_ADDI: begin
        o_ctrl.alusrc = 1'b1;
        o_ctrl.ext    = 1'b1;
        o_ctrl.aluop  = ALU_ADD;
        o_ctrl.dst    = 1'b1;
        o_ctrl.enw1   = 1'b1;
      end
      OP_LW, OP_LBU, OP_LBS: begin
        o_ctrl.alusrc = 1'b1;
        o_ctrl.ext    = 1'b1;
        o_ctrl.aluop  = ALU_ADD;
        o_ctrl.memr   = 1'b1;
        o_ctrl.wb     = 1'b1;
        o_ctrl.dst    = 1'b1;
        o_ctrl.enw1   = 1'b1;
        o_ctrl.mode   = (i_opcode != OP_LW);
      end
      OP_SW: begin
        o_ctrl.alusrc = 1'b1;
        o_ctrl.ext    = 1'b1;
        o_ctrl.aluop  = ALU_ADD;
        o_ctrl.rb     = 1'b1;
        o_ctrl.memw   = 1'b1;
      end
      OP_BGT, OP_BLT, OP_BEQ: begin
        o_ctrl.rb    = 1'b1;
        o_ctrl.aluop = ALU_SUB;
        o_ctrl.ext   = 1'b1;
        o_ctrl.mode  = i_mode;
        o_ctrl.is_br = 1'b1;
      end
      OP_JMP: o_ctrl.pcsrc = PC_JMP;
      OP_CALL: begin
        o_ctrl.pcsrc = PC_JMP;
        o_ctrl.enw2  = 1'b1;
      end
      OP_RET: o_ctrl.pcsrc = PC_RET;
      OP_SV: begin
        o_ctrl.addaddr = 1'b1;
        o_ctrl.adddata = 1'b1;
        o_ctrl.memw    = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
    // Address math always sign-extends; only LBu zero-extends the loaded byte
    o_ctrl.ext_late = o_ctrl.ext & (i_opcode != OP_LBU);
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the 16-bit RISC core.
module control_unit
  import control_unit_pkg::*;
(
  input  logic       clock,
  input  logic       resetN,
  input  logic [3:0] instructionCode,
  input  logic       zeroFlag,
  input  logic       mode,
  output logic [1:0] sigPCSrc,
  output logic       sigRB,
  output logic       sigENW1,
  output logic       sigENW2,
  output logic       sigALUSrc,
  output logic       sigExt,
  output logic [1:0] sigALUOp,
  output logic       sigAddAddress,
  output logic       sigAddData,
  output logic       sigMemR,
  output logic       sigMemW,
  output logic       sigWB,
  output logic       sigMode,
  output logic       sigDstReg,
  output logic       enIF,
  output logic       enID,
  output logic       enE,
  output logic       enMem,
  output logic       enWRB
);

  state_t     r_state, w_next;
  logic [3:0] r_opcode;
  logic       r_mode;
  ctrl_t      w_dec, w_out;

  control_unit_decode u_decode (
    .i_opcode (r_opcode),
    .i_mode   (r_mode),
    .o_ctrl   (w_dec)
  );

  // State register; opcode/mode captured on the edge leaving IF
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state  <= S_IF;
      r_opcode <= '0;
      r_mode   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IF) begin
        r_opcode <= instructionCode;
        r_mode   <= mode;
      end
    end
  end

  // Next-state: per-class path, always back to IF after the last stage
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF: w_next = S_ID;
      S_ID: begin
        if (r_opcode >= OP_JMP && r_opcode <= OP_RET) w_next = S_IF;
        else if (r_opcode == OP_SV)                  w_next = S_MEM;
        else                                         w_next = S_EX;
      end
      S_EX: begin
        if (w_dec.is_br)                                  w_next = S_IF;
        else if (r_opcode >= OP_LW && r_opcode <= OP_SW)  w_next = S_MEM;
        else                                              w_next = S_WB;
      end
      S_MEM: w_next = w_dec.memr ? S_WB : S_IF;
      S_WB:  w_next = S_IF;
      default: w_next = S_IF;
    endcase
  end

  // Outputs: stage enables plus decode narrowed to the stage that owns each strobe
  always_comb begin
    w_out = w_dec;
    if (r_state == S_IF) begin
      w_out = '0;
    end else begin
      w_out.enw1 = w_dec.enw1 & (r_state == S_WB);
      w_out.memr = w_dec.memr & (r_state == S_MEM);
      w_out.memw = w_dec.memw & (r_state == S_MEM);
      w_out.enw2 = w_dec.enw2 & (r_state == S_ID);
      if (w_dec.is_br)
        w_out.pcsrc = (r_state == S_EX && zeroFlag) ? PC_BR : PC_NEXT;
      if (r_state == S_MEM || r_state == S_WB)
        w_out.ext = w_dec.ext_late;
    end
    enIF          = (r_state == S_IF);
    enID          = (r_state == S_ID);
    enE           = (r_state == S_EX);
    enMem         = (r_state == S_MEM);
    enWRB         = (r_state == S_WB);
    sigPCSrc      = w_out.pcsrc;
    sigRB         = w_out.rb;
    sigENW1       = w_out.enw1;
    sigENW2       = w_out.enw2;
    sigALUSrc     = w_out.alusrc;
    sigExt        = w_out.ext;
    sigALUOp      = w_out.aluop;
    sigAddAddress = w_out.addaddr;
    sigAddData    = w_out.adddata;
    sigMemR       = w_out.memr;
    sigMemW       = w_out.memw;
    sigWB         = w_out.wb;
    sigMode       = w_out.mode;
    sigDstReg     = w_out.dst;
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit against a per-instruction stage-path model.
module tb_control_unit;

  logic       clock, resetN, zeroFlag, mode;
  logic [3:0] instructionCode;
  logic [1:0] sigPCSrc, sigALUOp;
  logic       sigRB, sigENW1, sigENW2, sigALUSrc, sigExt, sigAddAddress, sigAddData;
  logic       sigMemR, sigMemW, sigWB, sigMode, sigDstReg;
  logic       enIF, enID, enE, enMem, enWRB;

  int n_chk  = 0;
  int n_fail = 0;

  control_unit dut (
    .clock(clock), .resetN(resetN), .instructionCode(instructionCode),
    .zeroFlag(zeroFlag), .mode(mode),
    .sigPCSrc(sigPCSrc), .sigRB(sigRB), .sigENW1(sigENW1), .sigENW2(sigENW2),
    .sigALUSrc(sigALUSrc), .sigExt(sigExt), .sigALUOp(sigALUOp),
    .sigAddAddress(sigAddAddress), .sigAddData(sigAddData),
    .sigMemR(sigMemR), .sigMemW(sigMemW), .sigWB(sigWB), .sigMode(sigMode),
    .sigDstReg(sigDstReg),
    .enIF(enIF), .enID(enID), .enE(enE), .enMem(enMem), .enWRB(enWRB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // stage codes: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB
  function automatic logic [15:0] got_en();
    return {11'b0, enWRB, enMem, enE, enID, enIF};
  endfunction

  function automatic logic [15:0] got_sig();
    return {sigPCSrc, sigRB, sigENW1, sigENW2, sigALUSrc, sigExt, sigALUOp,
            sigAddAddress, sigAddData, sigMemR, sigMemW, sigWB, sigMode, sigDstReg};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Stage sequence of each instruction class; -1 past the end
  function automatic int stage_at(input logic [3:0] op, input int k);
    int p[5];
    int n;
    if (op <= 4'h4)      begin p = '{0, 1, 2, 4, 0}; n = 4; end
    else if (op <= 4'h7) begin p = '{0, 1, 2, 3, 4}; n = 5; end
    else if (op == 4'h8) begin p = '{0, 1, 2, 3, 0}; n = 4; end
    else if (op <= 4'hB) begin p = '{0, 1, 2, 0, 0}; n = 3; end
    else if (op <= 4'hE) begin p = '{0, 1, 0, 0, 0}; n = 2; end
    else                 begin p = '{0, 1, 3, 0, 0}; n = 3; end
    return (k < n) ? p[k] : -1;
  endfunction

  // Expected control word from the instruction-class rules
  function automatic logic [15:0] exp_sig(input logic [3:0] op, input logic m,
                                          input int st, input logic zf);
    logic rt, imm, ld, sw, br, sv;
    logic [1:0] pc, aop;
    logic rb, enw1, enw2, alusrc, ext, aa, ad, mr, mw, wb, md, dst;
    if (st == 0) return 16'h0;
    rt  = (op <= 4'h2);
    imm = (op == 4'h3) || (op == 4'h4);
    ld  = (op >= 4'h5) && (op <= 4'h7);
    sw  = (op == 4'h8);
    br  = (op >= 4'h9) && (op <= 4'hB);
    sv  = (op == 4'hF);
    if (br && st == 2 && zf)          pc = 2'b01;
    else if (op == 4'hC || op == 4'hD) pc = 2'b10;
    else if (op == 4'hE)               pc = 2'b11;
    else                               pc = 2'b00;
    rb     = sw | br;
    enw1   = (rt | imm | ld) && st == 4;
    enw2   = (op == 4'hD) && st == 1;
    alusrc = imm | ld | sw;
    ext    = (op == 4'h4) | sw | br | (ld && !(op == 4'h6 && st >= 3));
    if (rt)            aop = op[1:0];
    else if (op == 4'h3) aop = 2'b00;
    else if (imm | ld | sw) aop = 2'b01;
    else if (br)       aop = 2'b10;
    else               aop = 2'b00;
    aa  = sv;
    ad  = sv;
    mr  = ld && st == 3;
    mw  = (sw | sv) && st == 3;
    wb  = ld;
    md  = (op == 4'h6 || op == 4'h7) ? 1'b1 : (br ? m : 1'b0);
    dst = rt | imm | ld;
    return {pc, rb, enw1, enw2, alusrc, ext, aop, aa, ad, mr, mw, wb, md, dst};
  endfunction

  // Runs one instruction; entered at a falling edge with the FSM in IF.
  // zsel: 0/1 forces zeroFlag, 2 randomizes it each cycle.
  task automatic run_instr(input logic [3:0] op, input logic m, input int zsel);
    int st;
    logic zf;
    for (int k = 0; stage_at(op, k) >= 0; k++) begin
      st = stage_at(op, k);
      if (k == 0) begin
        instructionCode = op;
        mode            = m;
      end else begin
        instructionCode = 4'($urandom);
        mode            = 1'($urandom);
      end
      zf = (zsel == 2) ? 1'($urandom) : 1'(zsel);
      zeroFlag = zf;
      #1;
      chk($sformatf("en op%0h st%0d", op, st), got_en(), 16'(1 << st));
      chk($sformatf("sig op%0h st%0d m%0d zf%0d", op, st, m, zf), got_sig(),
          exp_sig(op, m, st, zf));
      @(negedge clock);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0; zeroFlag = 1'b0; mode = 1'b0; instructionCode = 4'h0;
    #3;
    chk("reset en", got_en(), 16'h0001);
    chk("reset sig", got_sig(), 16'h0000);
    @(negedge clock);
    resetN = 1'b1;

    // Directed cases
    run_instr(4'h1, 1'b0, 2);   // ADD
    run_instr(4'h7, 1'b0, 2);   // LBs
    run_instr(4'h6, 1'b1, 2);   // LBu
    run_instr(4'hB, 1'b0, 1);   // BEQ taken
    run_instr(4'hB, 1'b1, 0);   // BEQ not taken
    run_instr(4'hD, 1'b0, 2);   // CALL
    run_instr(4'hE, 1'b0, 2);   // RET
    run_instr(4'hF, 1'b0, 2);   // Sv mode 0
    run_instr(4'hF, 1'b1, 2);   // Sv mode 1

    // Asynchronous reset in the middle of EX
    instructionCode = 4'h1; mode = 1'b0;
    @(negedge clock);            // ID
    @(negedge clock);            // EX
    #2;
    chk("pre-reset en EX", got_en(), 16'h0004);
    resetN = 1'b0;
    #1;
    chk("midEX reset en", got_en(), 16'h0001);
    chk("midEX reset sig", got_sig(), 16'h0000);
    @(negedge clock);
    chk("held reset en", got_en(), 16'h0001);
    resetN = 1'b1;
    run_instr(4'h1, 1'b0, 2);    // IF then ID after release

    // Random instruction stream
    for (int i = 0; i < 300; i++)
      run_instr(4'($urandom), 1'($urandom), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
